// File: rtl/jedro_1_lsu_ctrl.sv
// Load/store sequencer: legality/alignment check, req/gnt/rvalid bus handshake,
// byte-lane steering for stores and alignment/extension of load data.
module jedro_1_lsu_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ctrl_valid_i,
    input  logic [3:0]                ctrl_i,
    input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      ready_o,
    output logic                      exc_o,
    output logic [ADDR_WIDTH-1:0]     exc_addr_o,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    output logic [ADDR_WIDTH-1:0]     data_addr_o,
    output logic                      data_we_o,
    output logic [3:0]                data_be_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i,
    output logic                      wb_valid_o,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t state, state_nxt;

    logic                      is_store;
    logic [2:0]                funct3;
    logic                      legal;
    logic                      misalign;
    logic                      fault;
    logic                      accept;
    logic [3:0]                be_new;
    logic [DATA_WIDTH-1:0]     wdata_new;

    logic                      op_store;
    logic [2:0]                op_funct3;
    logic [1:0]                op_off;
    logic [REG_ADDR_WIDTH-1:0] op_rd;

    logic [7:0]                byte_sel;
    logic [15:0]               half_sel;
    logic [DATA_WIDTH-1:0]     load_data;

    assign is_store = ctrl_i[3];
    assign funct3   = ctrl_i[2:0];
    assign ready_o  = (state == S_IDLE);

    always_comb begin
        legal = 1'b0;
        if (is_store) legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else          legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                              (funct3 == 3'b100) || (funct3 == 3'b101);
    end

    // funct3[1:0] encodes the access size for both loads and stores
    always_comb begin
        misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   misalign = addr_i[0];
            2'b10:   misalign = |addr_i[1:0];
            default: misalign = 1'b0;
        endcase
    end

    assign fault  = !legal || misalign;
    assign accept = (state == S_IDLE) && ctrl_valid_i && !fault;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = '0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << addr_i[1:0];
                    wdata_new = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = wdata_i;
                end
            endcase
        end
    end

    assign byte_sel = data_rdata_i[8*op_off +: 8];
    assign half_sel = data_rdata_i[16*op_off[1] +: 16];

    // funct3[2] set means unsigned (LBU/LHU)
    always_comb begin
        case (op_funct3[1:0])
            2'b00:   load_data = {{(DATA_WIDTH-8){byte_sel[7] & ~op_funct3[2]}}, byte_sel};
            2'b01:   load_data = {{(DATA_WIDTH-16){half_sel[15] & ~op_funct3[2]}}, half_sel};
            default: load_data = data_rdata_i;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)        state_nxt = S_REQ;
            S_REQ:   if (data_gnt_i)    state_nxt = S_WAIT;
            S_WAIT:  if (data_rvalid_i) state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exc_o        <= 1'b0;
            exc_addr_o   <= '0;
            data_req_o   <= 1'b0;
            data_addr_o  <= '0;
            data_we_o    <= 1'b0;
            data_be_o    <= '0;
            data_wdata_o <= '0;
            wb_valid_o   <= 1'b0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            op_store     <= 1'b0;
            op_funct3    <= '0;
            op_off       <= '0;
            op_rd        <= '0;
        end else begin
            exc_o      <= (state == S_IDLE) && ctrl_valid_i && fault;
            wb_valid_o <= 1'b0;
            if ((state == S_IDLE) && ctrl_valid_i && fault) exc_addr_o <= addr_i;
            if (accept) begin
                data_req_o   <= 1'b1;
                data_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                data_we_o    <= is_store;
                data_be_o    <= be_new;
                data_wdata_o <= wdata_new;
                op_store     <= is_store;
                op_funct3    <= funct3;
                op_off       <= addr_i[1:0];
                op_rd        <= regdest_i;
            end
            if ((state == S_REQ) && data_gnt_i) data_req_o <= 1'b0;
            // loads to x0 complete on the bus but never write back
            if ((state == S_WAIT) && data_rvalid_i && !op_store && (op_rd != '0)) begin
                wb_valid_o <= 1'b1;
                wb_addr_o  <= op_rd;
                wb_data_o  <= load_data;
            end
        end
    end

endmodule
